sae_frame_writer: RTL and testbench

- Upstream producer for the 12-bit async FIFO, in the write clock domain.
- Accepts one SAE fast-channel sample pair (ch1, ch2, status) over a valid/ready handshake.
- Serialises the pair into a 4-word frame (header, ch1, ch2, CRC) and pushes each word into the FIFO write port, obeying write_full backpressure.
- Computes the SAE CRC-4 over the six data nibbles.

---
 rtl/sae_frame_writer.sv | 124 ++++++++++++
 tb/tb_sae_frame_writer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sae_frame_writer.sv
// SAE fast-channel frame writer: serialises one (ch1, ch2, status) pair into a
// four-word frame {header, ch1, ch2, CRC} and pushes it into the async FIFO.
module sae_frame_writer #(
  parameter int         DATASIZE = 12,
  parameter logic [3:0] SYNC_TAG = 4'hA,
  parameter logic [3:0] CRC_TAG  = 4'hC,
  parameter logic [3:0] CRC_SEED = 4'h5
) (
  input  logic                write_clk,
  input  logic                read_reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATASIZE-1:0] in_ch1,
  input  logic [DATASIZE-1:0] in_ch2,
  input  logic [3:0]          in_status,
  input  logic                write_full,
  output logic                write_enable,
  output logic [DATASIZE-1:0] write_data,
  output logic [7:0]          frames_written
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_CH1  = 3'd2;
  localparam logic [2:0] ST_CH2  = 3'd3;
  localparam logic [2:0] ST_CRC  = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [3:0]          frame_cnt_q, frame_cnt_d;
  logic [7:0]          frames_written_q, frames_written_d;
  logic [DATASIZE-1:0] ch1_q, ch1_d;
  logic [DATASIZE-1:0] ch2_q, ch2_d;
  logic [3:0]          status_q, status_d;
  logic [3:0]          crc_q, crc_d;
  logic [3:0]          crc_in;

  // CRC-4 (x^4+x^3+x^2+1), MSB-first over the six data nibbles; status excluded.
  function automatic logic [3:0] sae_crc4(input logic [23:0] data);
    logic [3:0] crc;
    logic       fb;
    crc = CRC_SEED;
    for (int i = 23; i >= 0; i--) begin
      fb  = crc[3] ^ data[i];
      crc = {crc[2:0], 1'b0} ^ (fb ? 4'hD : 4'h0);
    end
    return crc;
  endfunction

  always_comb begin
    crc_in = sae_crc4({in_ch1, in_ch2});
  end

  always_comb begin
    in_ready     = (state_q == ST_IDLE);
    write_enable = (state_q != ST_IDLE) && !write_full;
  end

  always_comb begin
    write_data = '0;
    case (state_q)
      ST_HDR:  write_data = {status_q, SYNC_TAG, frame_cnt_q};
      ST_CH1:  write_data = ch1_q;
      ST_CH2:  write_data = ch2_q;
      ST_CRC:  write_data = {CRC_TAG, 4'h0, crc_q};
      default: write_data = '0;
    endcase
  end

  // Word states only advance on a strobed write, so a full FIFO freezes the frame.
  always_comb begin
    state_d          = state_q;
    frame_cnt_d      = frame_cnt_q;
    frames_written_d = frames_written_q;
    ch1_d            = ch1_q;
    ch2_d            = ch2_q;
    status_d         = status_q;
    crc_d            = crc_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          ch1_d    = in_ch1;
          ch2_d    = in_ch2;
          status_d = in_status;
          crc_d    = crc_in;
          state_d  = ST_HDR;
        end
      end
      ST_HDR: if (write_enable) state_d = ST_CH1;
      ST_CH1: if (write_enable) state_d = ST_CH2;
      ST_CH2: if (write_enable) state_d = ST_CRC;
      ST_CRC: begin
        if (write_enable) begin
          state_d          = ST_IDLE;
          frame_cnt_d      = frame_cnt_q + 4'd1;
          frames_written_d = frames_written_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge write_clk or posedge read_reset) begin
    if (read_reset) begin
      state_q          <= ST_IDLE;
      frame_cnt_q      <= '0;
      frames_written_q <= '0;
      ch1_q            <= '0;
      ch2_q            <= '0;
      status_q         <= '0;
      crc_q            <= '0;
    end else begin
      state_q          <= state_d;
      frame_cnt_q      <= frame_cnt_d;
      frames_written_q <= frames_written_d;
      ch1_q            <= ch1_d;
      ch2_q            <= ch2_d;
      status_q         <= status_d;
      crc_q            <= crc_d;
    end
  end

  assign frames_written = frames_written_q;

endmodule

// File: tb/tb_sae_frame_writer.sv
// Testbench for sae_frame_writer: directed frame vectors, stall/reset/wrap
// sequences and random traffic against a word-queue reference model.
module tb_sae_frame_writer;

  logic        write_clk;
  logic        read_reset;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_ch1;
  logic [11:0] in_ch2;
  logic [3:0]  in_status;
  logic        write_full;
  logic        write_enable;
  logic [11:0] write_data;
  logic [7:0]  frames_written;

  int checks = 0;
  int errors = 0;
  int we_seen = 0;

  logic [11:0] exp_q[$];
  logic [3:0]  m_cnt;
  logic [7:0]  m_frames;

  typedef struct packed {
    logic [11:0] ch1;
    logic [11:0] ch2;
    logic [3:0]  status;
    logic [11:0] w0;
    logic [11:0] w1;
    logic [11:0] w2;
    logic [11:0] w3;
  } vec_t;

  sae_frame_writer dut (
    .write_clk      (write_clk),
    .read_reset     (read_reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_ch1         (in_ch1),
    .in_ch2         (in_ch2),
    .in_status      (in_status),
    .write_full     (write_full),
    .write_enable   (write_enable),
    .write_data     (write_data),
    .frames_written (frames_written)
  );

  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  function automatic logic [3:0] ref_crc(input logic [11:0] a, input logic [11:0] b);
    logic [23:0] bits;
    logic [3:0]  c;
    bits = {a, b};
    c = 4'h5;
    for (int i = 23; i >= 0; i--) begin
      if (c[3] ^ bits[i]) c = ((c << 1) & 4'hF) ^ 4'hD;
      else                c = (c << 1) & 4'hF;
    end
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [11:0] c1, input logic [11:0] c2,
                               input logic [3:0] st, input logic full);
    in_valid   = valid;
    in_ch1     = c1;
    in_ch2     = c2;
    in_status  = st;
    write_full = full;
  endtask

  task automatic modelReset();
    exp_q.delete();
    m_cnt    = 4'd0;
    m_frames = 8'd0;
  endtask

  // Model: a frame is just four pending words; one leaves per non-full cycle.
  task automatic modelStep();
    logic idle;
    idle = (exp_q.size() == 0);
    if (!idle && !write_full) begin
      if (exp_q.size() == 1) begin
        m_cnt    = m_cnt + 4'd1;
        m_frames = m_frames + 8'd1;
      end
      void'(exp_q.pop_front());
    end
    if (idle && in_valid) begin
      exp_q.push_back({in_status, 4'hA, m_cnt});
      exp_q.push_back(in_ch1);
      exp_q.push_back(in_ch2);
      exp_q.push_back({4'hC, 4'h0, ref_crc(in_ch1, in_ch2)});
    end
  endtask

  task automatic checkModel();
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() == 0});
    checkOutput("write_enable", {31'd0, write_enable}, {31'd0, (exp_q.size() != 0) && !write_full});
    checkOutput("write_data", {20'd0, write_data}, {20'd0, (exp_q.size() != 0) ? exp_q[0] : 12'h000});
    checkOutput("frames_written", {24'd0, frames_written}, {24'd0, m_frames});
  endtask

  task automatic tick();
    if (read_reset) modelReset();
    #1;
    checkModel();
    if (write_enable) we_seen++;
    if (!read_reset) modelStep();
    @(posedge write_clk);
    @(negedge write_clk);
  endtask

  task automatic doReset();
    read_reset = 1'b1;
    tick();
    read_reset = 1'b0;
  endtask

  vec_t vecs[3];
  logic [11:0] words[4];

  initial begin
    read_reset = 1'b1;
    applyStimulus(1'b0, 12'h000, 12'h000, 4'h0, 1'b0);
    modelReset();
    @(negedge write_clk);
    #1;
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset write_enable", {31'd0, write_enable}, 32'd0);
    checkOutput("reset write_data", {20'd0, write_data}, 32'h0);
    checkOutput("reset frames_written", {24'd0, frames_written}, 32'd0);
    doReset();

    vecs[0] = '{ch1: 12'h000, ch2: 12'h000, status: 4'h0, w0: 12'h0A0, w1: 12'h000, w2: 12'h000, w3: 12'hC0F};
    vecs[1] = '{ch1: 12'hABC, ch2: 12'h123, status: 4'h3, w0: 12'h3A1, w1: 12'hABC, w2: 12'h123, w3: 12'hC04};
    vecs[2] = '{ch1: 12'hABC, ch2: 12'h123, status: 4'hF, w0: 12'hFA2, w1: 12'hABC, w2: 12'h123, w3: 12'hC04};

    for (int v = 0; v < 3; v++) begin
      words[0] = vecs[v].w0;
      words[1] = vecs[v].w1;
      words[2] = vecs[v].w2;
      words[3] = vecs[v].w3;
      applyStimulus(1'b1, vecs[v].ch1, vecs[v].ch2, vecs[v].status, 1'b0);
      tick();
      applyStimulus(1'b0, 12'h000, 12'h000, 4'h0, 1'b0);
      for (int k = 0; k < 4; k++) begin
        #1;
        checkOutput($sformatf("vec%0d word%0d", v, k), {20'd0, write_data}, {20'd0, words[k]});
        checkOutput($sformatf("vec%0d busy%0d", v, k), {31'd0, in_ready}, 32'd0);
        tick();
      end
      checkOutput($sformatf("vec%0d frames", v), {24'd0, frames_written}, v + 1);
    end

    // Three-cycle stall while the CH1 word is on the bus.
    applyStimulus(1'b1, 12'hABC, 12'h555, 4'h1, 1'b0);
    tick();
    applyStimulus(1'b0, 12'h000, 12'h000, 4'h0, 1'b0);
    tick();
    write_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("stall we", {31'd0, write_enable}, 32'd0);
      checkOutput("stall data", {20'd0, write_data}, 32'hABC);
      tick();
    end
    write_full = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    checkOutput("stall frames", {24'd0, frames_written}, 32'd4);

    // in_valid held across three frames from a fresh reset.
    doReset();
    we_seen = 0;
    applyStimulus(1'b1, 12'h3C5, 12'h9E1, 4'h6, 1'b0);
    for (int k = 0; k < 15; k++) tick();
    in_valid = 1'b0;
    checkOutput("held writes", we_seen, 32'd12);
    checkOutput("held frames", {24'd0, frames_written}, 32'd3);

    // Reset while the CH2 word is pending.
    applyStimulus(1'b1, 12'h111, 12'h222, 4'h7, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    read_reset = 1'b1;
    #1;
    checkOutput("midreset we", {31'd0, write_enable}, 32'd0);
    checkOutput("midreset ready", {31'd0, in_ready}, 32'd1);
    checkOutput("midreset frames", {24'd0, frames_written}, 32'd0);
    tick();
    read_reset = 1'b0;
    applyStimulus(1'b1, 12'h444, 12'h888, 4'h2, 1'b0);
    tick();
    in_valid = 1'b0;
    #1;
    checkOutput("post-reset header", {20'd0, write_data}, 32'h2A0);
    for (int k = 0; k < 4; k++) tick();

    // Seventeen back-to-back frames wrap the 4-bit header count.
    doReset();
    for (int f = 0; f < 17; f++) begin
      applyStimulus(1'b1, 12'($urandom), 12'($urandom), 4'($urandom), 1'b0);
      tick();
      in_valid = 1'b0;
      if (f == 16) begin
        #1;
        checkOutput("wrap header cnt", {28'd0, write_data[3:0]}, 32'd0);
      end
      for (int k = 0; k < 4; k++) tick();
    end
    checkOutput("wrap frames", {24'd0, frames_written}, 32'd17);

    // Random traffic with backpressure and occasional resets.
    for (int n = 0; n < 600; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 12'($urandom), 12'($urandom), 4'($urandom),
                    $urandom_range(0, 3) == 0);
      read_reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    read_reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
